// File: rtl/ula_pkg.sv
// ula_pkg: shared constants and types for the ULA result-mux sequencer.
//   DATA_W          width of the ULA result bus
//   OP_SEL0..7      3-bit opcodes, one per mux input
//   state_t         sequencer FSM states (IDLE, SETTLE, HOLD)
//   SETTLE_CYC_DEF  default settle time in cycles
package ula_pkg;

    localparam int DATA_W = 4;

    localparam logic [2:0] OP_SEL0 = 3'd0;
    localparam logic [2:0] OP_SEL1 = 3'd1;
    localparam logic [2:0] OP_SEL2 = 3'd2;
    localparam logic [2:0] OP_SEL3 = 3'd3;
    localparam logic [2:0] OP_SEL4 = 3'd4;
    localparam logic [2:0] OP_SEL5 = 3'd5;
    localparam logic [2:0] OP_SEL6 = 3'd6;
    localparam logic [2:0] OP_SEL7 = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int SETTLE_CYC_DEF = 1;

endpackage

// File: rtl/ula_flags_4b.sv
// ula_flags_4b: combinational zero / negative flags of a 4-bit value.
// Ports:
//   val   in  4  value to inspect
//   zero  out 1  val == 0
//   neg   out 1  val[3] (two's-complement sign)
module ula_flags_4b
    import ula_pkg::*;
(
    input  logic [DATA_W-1:0] val,
    output logic              zero,
    output logic              neg
);

    assign zero = (val == '0);
    assign neg  = val[DATA_W-1];

endmodule

// File: rtl/ula_seq_4b.sv
// ula_seq_4b: sequencer in front of the 4-bit 8:1 ULA result mux.
// Accepts one opcode per cmd handshake, drives and holds the mux selects,
// waits SETTLE_CYC cycles, captures mux_f with zero/negative flags and
// offers it on the res handshake.
// Parameters: SETTLE_CYC (1..15) settle cycles, CNT_W op counter width.
// Optional build macro: ULA_SEQ_ACC_EN adds a 4-bit accumulator; when
// undefined cmd_acc is ignored and acc reads 0.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op[2:0], cmd_acc          opcode, accumulate request
//   mux_s0..mux_s2                registered mux selects
//   mux_f[3:0]                    mux result
//   res_valid/res_ready           result handshake
//   res_data[3:0], res_zero, res_neg  captured result and flags
//   acc[3:0]                      accumulator
//   op_cnt[CNT_W-1:0]             completed results, wrapping
module ula_seq_4b
    import ula_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_acc,
    output logic             mux_s0,
    output logic             mux_s1,
    output logic             mux_s2,
    input  logic [3:0]       mux_f,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic             res_zero,
    output logic             res_neg,
    output logic [3:0]       acc,
    output logic [CNT_W-1:0] op_cnt
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t            state_reg;
    logic [3:0]        settle_cnt_reg;
    logic [2:0]        mux_sel_reg;
    logic              res_valid_reg;
    logic [3:0]        res_data_reg;
    logic              res_zero_reg;
    logic              res_neg_reg;
    logic [CNT_W-1:0]  op_cnt_reg;

    logic [3:0]        cap_val;
    logic              cap_zero;
    logic              cap_neg;
    logic              capture;

    // The capture edge is the last SETTLE cycle; mux_f is only looked at here.
    assign capture = (state_reg == SETTLE) && (settle_cnt_reg == SETTLE_LAST);

`ifdef ULA_SEQ_ACC_EN
    logic [3:0] acc_reg;
    logic       acc_latch_reg;
    logic [3:0] acc_sum;

    assign acc_sum = acc_reg + mux_f;   // 4-bit add wraps modulo 16
    assign cap_val = acc_latch_reg ? acc_sum : mux_f;
    assign acc     = acc_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            acc_latch_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && cmd_valid)
                acc_latch_reg <= cmd_acc;
            if (capture && acc_latch_reg)
                acc_reg <= acc_sum;
        end
    end
`else
    logic cmd_acc_unused;

    assign cmd_acc_unused = cmd_acc;
    assign cap_val        = mux_f;
    assign acc            = '0;
`endif

    ula_flags_4b u_flags (
        .val  (cap_val),
        .zero (cap_zero),
        .neg  (cap_neg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            settle_cnt_reg <= '0;
            mux_sel_reg    <= '0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            res_zero_reg   <= 1'b0;
            res_neg_reg    <= 1'b0;
            op_cnt_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        mux_sel_reg    <= cmd_op;
                        settle_cnt_reg <= '0;
                        state_reg      <= SETTLE;
                    end
                end
                SETTLE: begin
                    settle_cnt_reg <= settle_cnt_reg + 4'd1;
                    if (capture) begin
                        res_data_reg  <= cap_val;
                        res_zero_reg  <= cap_zero;
                        res_neg_reg   <= cap_neg;
                        res_valid_reg <= 1'b1;
                        op_cnt_reg    <= op_cnt_reg + 1'b1;
                        state_reg     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Gated by rst_n so no command appears accepted while reset is held.
    assign cmd_ready = (state_reg == IDLE) && rst_n;
    assign mux_s0    = mux_sel_reg[0];
    assign mux_s1    = mux_sel_reg[1];
    assign mux_s2    = mux_sel_reg[2];
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_zero  = res_zero_reg;
    assign res_neg   = res_neg_reg;
    assign op_cnt    = op_cnt_reg;

endmodule

// File: tb/tb_ula_seq_4b.sv
module tb_ula_seq_4b;
    import ula_pkg::*;

    localparam int SETTLE = 3;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_acc;
    logic             mux_s0, mux_s1, mux_s2;
    logic [3:0]       mux_f;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_data;
    logic             res_zero;
    logic             res_neg;
    logic [3:0]       acc;
    logic [CNT_W-1:0] op_cnt;

    int n_cmp = 0;
    int n_mis = 0;
    int m_acc = 0;
    int m_cnt = 0;
    int m_mux = 0;
    int n_txn = 0;

    ula_seq_4b #(.SETTLE_CYC(SETTLE), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_acc   (cmd_acc),
        .mux_s0    (mux_s0),
        .mux_s1    (mux_s1),
        .mux_s2    (mux_s2),
        .mux_f     (mux_f),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_neg   (res_neg),
        .acc       (acc),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel();
        return {29'd0, mux_s2, mux_s1, mux_s0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full command: accept, settle (with optional glitch value, -1 = random),
    // capture, bp cycles of backpressure, then release.
    task automatic run_op(input logic [2:0] op, input bit use_acc, input logic [3:0] f,
                          input int glitch, input int bp);
        int exp_data;
        chk("idle_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_acc   = use_acc;
        mux_f     = 4'($urandom);
        res_ready = 1'($urandom_range(0, 1));
        tick();
        chk("acc_sel", sel(), op);
        chk("acc_ready", cmd_ready, 0);
        chk("acc_valid", res_valid, 0);
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 3'($urandom);
        cmd_acc   = 1'($urandom);
        for (int k = 1; k <= SETTLE; k++) begin
            if (k == SETTLE) mux_f = f;
            else mux_f = (glitch < 0) ? 4'($urandom) : 4'(glitch);
            res_ready = 1'($urandom_range(0, 1));
            tick();
            if (k < SETTLE) chk("settle_valid", res_valid, 0);
        end
`ifdef ULA_SEQ_ACC_EN
        if (use_acc) begin
            m_acc    = (m_acc + int'(f)) % 16;
            exp_data = m_acc;
        end else begin
            exp_data = int'(f);
        end
`else
        exp_data = int'(f);
`endif
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_mux = int'(op);
        chk("cap_valid", res_valid, 1);
        chk("cap_data", res_data, exp_data);
        chk("cap_zero", res_zero, (exp_data == 0) ? 1 : 0);
        chk("cap_neg", res_neg, (exp_data >= 8) ? 1 : 0);
        chk("cap_acc", acc, m_acc);
        chk("cap_cnt", op_cnt, m_cnt);
        chk("cap_sel", sel(), op);
        n_txn++;
        $display("txn %0d: op=%0d acc_req=%0d f=%0h -> data=%0h acc=%0h cnt=%0d bp=%0d",
                 n_txn, op, use_acc, f, res_data, acc, op_cnt, bp);
        for (int b = 0; b < bp; b++) begin
            res_ready = 1'b0;
            cmd_valid = 1'b1;
            cmd_op    = 3'($urandom);
            cmd_acc   = 1'($urandom);
            mux_f     = 4'($urandom);
            tick();
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, exp_data);
            chk("hold_ready", cmd_ready, 0);
            chk("hold_sel", sel(), op);
        end
        res_ready = 1'b1;
        tick();
        chk("rel_valid", res_valid, 0);
        chk("rel_data", res_data, exp_data);
        chk("rel_ready", cmd_ready, 1);
        chk("rel_sel", sel(), op);
        cmd_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'b0;
            cmd_op    = 3'($urandom);
            res_ready = 1'($urandom_range(0, 1));
            tick();
            chk("idle_ready", cmd_ready, 1);
            chk("idle_valid", res_valid, 0);
            chk("idle_sel", sel(), m_mux);
        end
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        cmd_acc   = 1'b1;
        mux_f     = 4'hF;
        res_ready = 1'b1;

        // Reset held two cycles with a command pending.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ready", cmd_ready, 0);
            chk("rst_valid", res_valid, 0);
            chk("rst_data", res_data, 0);
            chk("rst_zero", res_zero, 0);
            chk("rst_neg", res_neg, 0);
            chk("rst_acc", acc, 0);
            chk("rst_cnt", op_cnt, 0);
            chk("rst_sel", sel(), 0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_valid", res_valid, 0);
        idle_cycles(1);

        run_op(OP_SEL5, 1'b0, 4'b1000, -1, 0);
        run_op(3'($urandom), 1'b0, 4'($urandom), -1, 5);
        run_op(OP_SEL2, 1'b0, 4'h0, 15, 1);
        idle_cycles(2);

        // Reset while the command is still settling.
        cmd_valid = 1'b1;
        cmd_op    = OP_SEL6;
        cmd_acc   = 1'b1;
        tick();
        chk("mid_sel", sel(), OP_SEL6);
        cmd_valid = 1'b0;
        tick();
        chk("mid_valid", res_valid, 0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_cnt", op_cnt, 0);
        chk("mid_rst_sel", sel(), 0);
        chk("mid_rst_acc", acc, 0);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", cmd_ready, 1);
        m_acc = 0;
        m_cnt = 0;
        m_mux = 0;
        idle_cycles(1);

        // Accumulate 9 twice: 9 then (9+9) mod 16 = 2 when the feature is built in.
        run_op(OP_SEL1, 1'b1, 4'd9, -1, 0);
        run_op(OP_SEL3, 1'b1, 4'd9, -1, 0);

        for (int i = 0; i < 254; i++) begin
            idle_cycles($urandom_range(0, 1));
            run_op(3'($urandom), 1'($urandom), 4'($urandom), -1,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
        chk("cnt_wrap", op_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ula_seq_4b.md
Name: ula_seq_4b

Overview:
- Sequencer that sits directly upstream of the 4-bit 8:1 ULA result mux and consumes its output.
- Accepts one opcode per valid/ready handshake and drives the mux select lines, holding them stable.
- Waits a programmable settle time, then registers the 4-bit result with zero/negative flags.
- Presents the result on a valid/ready output handshake to the next stage.

Parameters:
- SETTLE_CYC, 1, cycles between select update and result capture; legal range 1..15.
- CNT_W, 8, width of completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept command
- cmd_op  in  3  opcode; bit0→mux_s0, bit1→mux_s1, bit2→mux_s2
- cmd_acc  in  1  also load result into accumulator (see Optional Feature)
- mux_s0  out  1  mux select bit 0
- mux_s1  out  1  mux select bit 1
- mux_s2  out  1  mux select bit 2
- mux_f  in  4  mux result
- res_valid  out  1  registered result available
- res_ready  in  1  downstream accepts result
- res_data  out  4  captured mux_f
- res_zero  out  1  res_data == 0
- res_neg  out  1  res_data[3]
- acc  out  4  accumulator
- op_cnt  out  CNT_W  completed results, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, mux_s*=0, res_valid=0, res_data=0, res_zero=0, res_neg=0, acc=0, op_cnt=0, settle counter=0.
- Reset mid-operation aborts it: no result emitted, op_cnt unchanged from 0.
- Reset wins over every other event on the same edge.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - cmd_ready=1 (combinational from state).
  - On cmd_valid at an edge: load mux_s2..s0 from cmd_op, latch cmd_acc, clear counter, go to SETTLE.
- SETTLE:
  - cmd_ready=0; counter increments each cycle.
  - At the edge where counter == SETTLE_CYC-1:
    - capture res_data←mux_f, res_zero←(mux_f==0), res_neg←mux_f[3];
    - res_valid←1, op_cnt←op_cnt+1, go to HOLD.
  - mux_f is sampled only at that edge; earlier glitches are ignored.
- HOLD:
  - cmd_ready=0; res_* and mux_s* held stable.
  - On res_ready=1 at an edge: res_valid←0, go to IDLE. res_data and flags keep their last value.
- Latency: res_valid rises SETTLE_CYC edges after the accept edge.
- Throughput: one op per SETTLE_CYC+2 cycles when res_ready is held high.
- In SETTLE or HOLD, cmd_valid is ignored and the command is not consumed. cmd_op/cmd_acc may change freely.
- res_ready while res_valid=0 has no effect.
- mux_s* change only on the accept edge and retain their value in IDLE.
- op_cnt wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro: ULA_SEQ_ACC_EN.
- Defined:
  - On the capture edge, if latched cmd_acc=1: acc←(acc + mux_f) mod 16, and res_data←that sum instead of mux_f. Flags follow res_data.
  - If cmd_acc=0: acc is unchanged and res_data=mux_f.
- Undefined: cmd_acc ignored, acc constant 0, res_data always mux_f.

Decomposition:
- Package ula_pkg:
  - data width constant 4;
  - 3-bit opcode constants OP_SEL0..OP_SEL7;
  - FSM state typedef (IDLE, SETTLE, HOLD);
  - default SETTLE_CYC.
- One natural sub-module: ula_flags_4b, combinational zero/negative from a 4-bit value. Instantiated once on the capture-path value.
- Sequencer FSM, counter, and accumulator stay in ula_seq_4b.

Test Plan:
1. Reset then idle: rst_n low 2 cycles with cmd_valid=1 → cmd_ready=0 during reset, all outputs 0. After release: cmd_ready=1, res_valid=0.
2. Single op, SETTLE_CYC=1: cmd_op=3'b101, mux_f=4'b1000 → mux_s2..s0=1,0,1 after accept. One edge later res_valid=1, res_data=8, res_neg=1, res_zero=0, op_cnt=1.
3. Backpressure: res_ready=0 for 5 cycles with cmd_valid=1, cmd_op changing → res_data, mux_s*, cmd_ready=0 stable. res_ready=1 → res_valid drops next edge. Next cmd accepted one cycle later.
4. SETTLE_CYC=3 with a mux_f glitch 4'hF at settle cycle 1, then final 4'h0 → res_data=0, res_zero=1. res_valid appears 3 edges after accept.
5. Reset mid-SETTLE → no res_valid, op_cnt=0, state IDLE. A subsequent op completes normally.
6. ULA_SEQ_ACC_EN, cmd_acc=1, mux_f values 9 then 9 → acc=9 then 2 (wrap), res_data=2.
7. 256 completed ops with CNT_W=8 → op_cnt returns to 0.
